// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 mux, its downstream deserializer and tester.
package mux_pkg;

    localparam int         DEF_WIDTH = 8;
    localparam logic [7:0] DEF_SYNC  = 8'hA5;

    // Deserializer alignment state
    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } deser_state_e;

endpackage

// File: rtl/mux_deser_outreg.sv
// One-word holding register for the deserializer: valid/ready handshake and
// sticky overflow when a completed word arrives while the register is still full.
module mux_deser_outreg
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overflow
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (load) begin
            // A ready consumer frees the slot on the same edge the new word lands
            if (!valid_q || word_ready) begin
                word_d  = load_word;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign overflow   = ovf_q;

endmodule

// File: rtl/mux_deser.sv
// Serial-to-parallel deserializer: hunts for SYNC, then packs MSB-first words.
// Define MUX_DESER_PARITY_EN to expect an even-parity bit after every word.
module mux_deser
    import mux_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC  = WIDTH'(DEF_SYNC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             data_en,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             locked,
    output logic             overflow,
    output logic             parity_err
);

    localparam int            CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] FILL_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
`ifdef MUX_DESER_PARITY_EN
    localparam logic [CW-1:0] WORD_END = CW'(WIDTH);
`else
    localparam logic [CW-1:0] WORD_END = CW'(WIDTH - 1);
`endif

    deser_state_e     state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word_data;
    logic             word_done;
    logic             perr_d;

`ifdef MUX_DESER_PARITY_EN
    function automatic logic even_parity_ok(input logic [WIDTH-1:0] d, input logic p);
        return ~(^d ^ p);
    endfunction
`endif

    assign shifted = {sr_q[WIDTH-2:0], data_in};

    // cnt_q is the fill counter while hunting and the bit index while locked
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        word_data = shifted;
        perr_d    = 1'b0;
        if (data_en) begin
            sr_d = shifted;
            case (state_q)
                ST_HUNT: begin
                    if (cnt_q >= LAST_BIT && shifted == SYNC) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                    end else if (cnt_q != FILL_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (cnt_q == WORD_END) begin
                        cnt_d = '0;
`ifdef MUX_DESER_PARITY_EN
                        // Data bits already sit in sr_q; this bit is parity
                        word_data = sr_q;
                        if (even_parity_ok(sr_q, data_in)) begin
                            word_done = 1'b1;
                        end else begin
                            perr_d  = 1'b1;
                            state_d = ST_HUNT;
                        end
`else
                        word_done = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HUNT;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MUX_DESER_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    logic unused_sr_msb;
    logic unused_perr;

    assign unused_sr_msb = sr_q[WIDTH-1];
    assign unused_perr   = perr_d;
    assign parity_err    = 1'b0;
`endif

    assign locked = (state_q == ST_LOCKED);

    mux_deser_outreg #(
        .WIDTH(WIDTH)
    ) u_outreg (
        .clk        (clk),
        .reset      (reset),
        .load       (word_done),
        .load_word  (word_data),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_mux_deser.sv
// Self-checking bench for mux_deser (default build): directed scenarios plus
// randomized traffic compared against a queue-based behavioural model.
module tb_mux_deser;
    import mux_pkg::*;

    localparam int         W  = DEF_WIDTH;
    localparam logic [W-1:0] SY = DEF_SYNC;

    logic         clk = 1'b0;
    logic         reset;
    logic         data_in;
    logic         data_en;
    logic         word_ready;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         locked;
    logic         overflow;
    logic         parity_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit           hunt_q[$];
    bit           word_q[$];
    bit           m_locked;
    bit           m_valid;
    bit           m_ovf;
    logic [W-1:0] m_word;

    mux_deser #(.WIDTH(W), .SYNC(SY)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_en    (data_en),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .locked     (locked),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic model_update(input bit rst, input bit en, input bit din, input bit rdy);
        bit           done = 1'b0;
        logic [W-1:0] v    = '0;
        if (rst) begin
            hunt_q.delete();
            word_q.delete();
            m_locked = 1'b0;
            m_valid  = 1'b0;
            m_ovf    = 1'b0;
            m_word   = '0;
            return;
        end
        if (en) begin
            if (!m_locked) begin
                hunt_q.push_back(din);
                if (hunt_q.size() > W) void'(hunt_q.pop_front());
                if (hunt_q.size() == W) begin
                    foreach (hunt_q[i]) v = {v[W-2:0], hunt_q[i]};
                    if (v == SY) begin
                        m_locked = 1'b1;
                        hunt_q.delete();
                    end
                end
            end else begin
                word_q.push_back(din);
                if (word_q.size() == W) begin
                    foreach (word_q[i]) v = {v[W-2:0], word_q[i]};
                    done = 1'b1;
                    word_q.delete();
                end
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_word  = v;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit din, input bit rdy);
        reset      = rst;
        data_en    = en;
        data_in    = din;
        word_ready = rdy;
        @(posedge clk);
        model_update(rst, en, din, rdy);
        @(negedge clk);
        check("word_valid", 32'(word_valid), 32'(m_valid));
        check("word_out",   32'(word_out),   32'(m_word));
        check("locked",     32'(locked),     32'(m_locked));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("parity_err", 32'(parity_err), 32'd0);
    endtask

    // Sends the top n bits of v MSB-first; tog inserts a disabled cycle with junk data first
    task automatic send_bits(input logic [7:0] v, input int n, input bit tog, input bit rdy);
        for (int i = 7; i >= 8 - n; i--) begin
            if (tog) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), rdy);
            step(1'b0, 1'b1, v[i], rdy);
        end
    endtask

    initial begin
        reset      = 1'b1;
        data_en    = 1'b0;
        data_in    = 1'b0;
        word_ready = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_valid",  32'(word_valid), 32'd0);
        check("rst_word",   32'(word_out),   32'd0);
        check("rst_locked", 32'(locked),     32'd0);
        check("rst_ovf",    32'(overflow),   32'd0);

        // Sync then one word, consumer always ready
        send_bits(8'hA5, 7, 1'b0, 1'b1);
        check("t1_prelock", 32'(locked), 32'd0);
        send_bits(8'hA5 << 7, 1, 1'b0, 1'b1);
        check("t1_lock", 32'(locked), 32'd1);
        send_bits(8'h3C, 8, 1'b0, 1'b1);
        check("t1_word",  32'(word_out),   32'h3C);
        check("t1_valid", 32'(word_valid), 32'd1);

        // Same stream with data_en toggling every cycle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'hA5, 8, 1'b1, 1'b1);
        check("t2_lock", 32'(locked), 32'd1);
        send_bits(8'h3C, 8, 1'b1, 1'b1);
        check("t2_word",  32'(word_out),   32'h3C);
        check("t2_valid", 32'(word_valid), 32'd1);

        // Consumer stalled: second word dropped, overflow sticks
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'hA5, 8, 1'b0, 1'b0);
        send_bits(8'h3C, 8, 1'b0, 1'b0);
        send_bits(8'h5A, 8, 1'b0, 1'b0);
        check("t3_word",  32'(word_out),   32'h3C);
        check("t3_ovf",   32'(overflow),   32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_drain", 32'(word_valid), 32'd0);
        check("t3_ovf2",  32'(overflow),   32'd1);

        // Accept and reload on the same edge
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'hA5, 8, 1'b0, 1'b0);
        send_bits(8'h3C, 8, 1'b0, 1'b0);
        send_bits(8'h5A, 7, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("t4_word",  32'(word_out),   32'h5A);
        check("t4_valid", 32'(word_valid), 32'd1);
        check("t4_ovf",   32'(overflow),   32'd0);

        // Reset mid-word, then no word without re-sync
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'hA5, 8, 1'b0, 1'b0);
        send_bits(8'h3C, 4, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_locked", 32'(locked),     32'd0);
        check("t5_valid",  32'(word_valid), 32'd0);
        send_bits(8'h3C, 8, 1'b0, 1'b0);
        check("t5_nosync", 32'(word_valid), 32'd0);
        send_bits(8'hA5, 8, 1'b0, 1'b0);
        send_bits(8'h3C, 8, 1'b0, 1'b0);
        check("t5_word",  32'(word_out),   32'h3C);
        check("t5_valid2", 32'(word_valid), 32'd1);

        // Randomized traffic against the model
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 800; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 1) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
            end else if (r < 4) begin
                send_bits(SY, 8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                step(1'b0, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) < 4));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
